vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: cycles a pending CPU access may lose to video before it is forced to win (range 1..15).
REQ-002 SHALL have port clk  in  1: single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  in  1: synchronous, active-low reset.
REQ-004 SHALL have port cpu_req  in  1: CPU VRAM memory cycle active; level, held until cpu_wait_n is high.
REQ-005 SHALL have port cpu_we  in  1: 1=write, 0=read; valid while cpu_req.
REQ-006 SHALL have port cpu_addr  in  13: CPU VRAM offset.
REQ-007 SHALL have port cpu_din  in  8: CPU write data.
REQ-008 SHALL have port rd_bank  in  6: plane select for reads, bit n = plane n.
REQ-009 SHALL have port wr_bank  in  6: plane select for writes, bit n = plane n.
REQ-010 SHALL have port cpu_dout  out  8: registered read data.
REQ-011 SHALL have port cpu_wait_n  out  1: low = CPU must stall.
REQ-012 SHALL have port vid_req  in  1: video fetch request; level.
REQ-013 SHALL have port vid_addr  in  13: video fetch address.
REQ-014 SHALL have port vid_ack  out  1: one-cycle pulse; vid_data valid that cycle.
REQ-015 SHALL have port vid_data  out  48: planes 5..0, plane n in bits [8n+7:8n], registered.
REQ-016 SHALL have port ram_addr  out  13: shared single-port VRAM address.
REQ-017 SHALL have port ram_ce_n  out  6: per-plane chip enable, active low.
REQ-018 SHALL have port ram_we_n  out  1: write strobe, active low.
REQ-019 SHALL have port ram_din  out  8: write data to all planes.
REQ-020 SHALL have port ram_q  in  48: plane read data, valid one cycle after address/ce presented.

Function
REQ-021 SHALL implement states IDLE, VID_A, VID_D, CPU_A, CPU_D.
REQ-022 SHALL, in IDLE, go to CPU_A if cpu_pending and (not vid_req or starve=MAX_WAIT); else to VID_A if vid_req; else stay.
REQ-023 SHALL define cpu_pending = cpu_req and not done, where done sets in CPU_D and clears the cycle cpu_req is low.
REQ-024 SHALL drive cpu_wait_n = not cpu_pending combinationally, so the CPU stalls in the same cycle cpu_req rises.
REQ-025 SHALL, in VID_A, drive ram_addr=vid_addr, ram_ce_n=6'b000000, ram_we_n=1; then go to VID_D.
REQ-026 SHALL, in VID_D, register ram_q into vid_data, pulse vid_ack for exactly this cycle, and return to IDLE.
REQ-027 SHALL, in CPU_A, sample cpu_addr, cpu_we and bank; drive ram_addr=cpu_addr and ram_ce_n=~rd_bank (read) or ~wr_bank (write); drive ram_we_n=0 and ram_din=cpu_din for writes only; then go to CPU_D.
REQ-028 SHALL, in CPU_D for a read, set cpu_dout to the bitwise OR of the ram_q bytes of planes selected by the rd_bank sampled in CPU_A; leave cpu_dout unchanged for writes; set done; return to IDLE.
REQ-029 SHALL, outside CPU_A/VID_A, drive ram_ce_n=6'h3f and ram_we_n=1; ram_we_n SHALL never be low outside CPU_A.
REQ-030 SHALL keep a 4-bit starve counter: +1 (saturating at MAX_WAIT) each IDLE cycle that cpu_pending and VID_A is chosen; cleared on entry to CPU_A.
REQ-031 SHALL treat rd_bank=0 as a completed read returning 8'h00, and wr_bank=0 as a completed write with no plane enabled.
REQ-032 SHALL service each access in 2 cycles; CPU worst-case latency = 1 + 2*(MAX_WAIT+1) cycles from cpu_req rise to cpu_wait_n high.
REQ-033 SHALL not re-serve a held cpu_req; a new access requires cpu_req low for at least one cycle.

Reset
REQ-034 SHALL, while reset_n=0 at a clock edge, force state IDLE, starve=0, done=0, cpu_dout=8'h00, vid_data=0, vid_ack=0; ram_ce_n=6'h3f, ram_we_n=1 and ram_addr=0 follow from IDLE.
REQ-035 SHALL abandon any in-flight access on reset; no write strobe SHALL occur in the reset cycle.

Verification
REQ-036 SHALL cover: write cpu_addr=0x0100, cpu_din=0xA5, wr_bank=6'b000101, no vid_req -> CPU_A has ram_ce_n=6'b111010 and ram_we_n=0; cpu_wait_n high 2 cycles after cpu_req rise.
REQ-037 SHALL cover: planes 0/1 hold 0x0F/0xF0 at 0x0100, read with rd_bank=6'b000011 -> cpu_dout=0xFF; with rd_bank=0 -> cpu_dout=0x00.
REQ-038 SHALL cover: vid_req held high, vid_addr=0x1FFF -> vid_ack pulses every 2 cycles, vid_data equals the 48-bit ram_q.
REQ-039 SHALL cover: vid_req held high, CPU read issued, MAX_WAIT=4 -> exactly 4 video grants, then CPU_A; cpu_wait_n rises 11 cycles after cpu_req.
REQ-040 SHALL cover: reset_n low during CPU_A of a write -> next cycle IDLE, ram_we_n=1, cpu_dout=0; after release, a held cpu_req is served again.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port, six-plane VRAM between CPU accesses
// and video fetches. Each access takes two cycles (address, data). Video wins
// ties until a waiting CPU access has lost MAX_WAIT times, then the CPU is
// forced in. Arbitration is re-evaluated in IDLE and at the end of every
// access (VID_D / CPU_D), so back-to-back accesses need no idle cycle.
module vram_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic [5:0]  rd_bank,
    input  logic [5:0]  wr_bank,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait_n,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic [47:0] vid_data,
    output logic [12:0] ram_addr,
    output logic [5:0]  ram_ce_n,
    output logic        ram_we_n,
    output logic [7:0]  ram_din,
    input  logic [47:0] ram_q
);

    typedef enum logic [2:0] {IDLE, VID_A, VID_D, CPU_A, CPU_D} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        done_q, done_d;
    logic        we_q, we_d;
    logic [5:0]  rd_bank_q, rd_bank_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [47:0] vid_data_q, vid_data_d;
    logic        vid_ack_q, vid_ack_d;

    logic        cpu_pending;
    logic        arb_point;
    logic [7:0]  rd_or;

    // The access completing in CPU_D already counts as done, so the CPU is
    // released during CPU_D and that access is never re-arbitrated.
    assign cpu_pending = cpu_req && !done_q && (state_q != CPU_D);
    assign arb_point   = (state_q == IDLE) || (state_q == VID_D) || (state_q == CPU_D);
    assign cpu_wait_n  = !cpu_pending;

    assign cpu_dout = cpu_dout_q;
    assign vid_data = vid_data_q;
    assign vid_ack  = vid_ack_q;

    // OR of the bytes of the planes selected by the read bank sampled in CPU_A.
    always_comb begin
        rd_or = 8'h00;
        for (int i = 0; i < 6; i++) begin
            rd_or = rd_or | (ram_q[8*i +: 8] & {8{rd_bank_q[i]}});
        end
    end

    // Next-state, starvation counter and data capture.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        we_d       = we_q;
        rd_bank_d  = rd_bank_q;
        cpu_dout_d = cpu_dout_q;
        vid_data_d = vid_data_q;
        vid_ack_d  = 1'b0;

        // done holds off a still-held cpu_req until it drops for a cycle.
        if (!cpu_req)
            done_d = 1'b0;
        else if (state_q == CPU_D)
            done_d = 1'b1;
        else
            done_d = done_q;

        case (state_q)
            VID_A: state_d = VID_D;
            VID_D: begin
                vid_data_d = ram_q;
                vid_ack_d  = 1'b1;
            end
            CPU_A: begin
                state_d   = CPU_D;
                we_d      = cpu_we;
                rd_bank_d = rd_bank;
            end
            CPU_D: begin
                if (!we_q)
                    cpu_dout_d = rd_or;
            end
            default: ;
        endcase

        if (arb_point) begin
            if (cpu_pending && (!vid_req || starve_q >= MAX_W)) begin
                state_d  = CPU_A;
                starve_d = 4'd0;
            end else if (vid_req) begin
                state_d = VID_A;
                if (cpu_pending && starve_q < MAX_W)
                    starve_d = starve_q + 4'd1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // VRAM drive; gated by reset so an in-flight access is abandoned at once.
    always_comb begin
        ram_addr = 13'd0;
        ram_ce_n = 6'h3f;
        ram_we_n = 1'b1;
        ram_din  = 8'h00;
        if (reset_n) begin
            case (state_q)
                VID_A: begin
                    ram_addr = vid_addr;
                    ram_ce_n = 6'h00;
                end
                CPU_A: begin
                    ram_addr = cpu_addr;
                    ram_ce_n = cpu_we ? ~wr_bank : ~rd_bank;
                    if (cpu_we) begin
                        ram_we_n = 1'b0;
                        ram_din  = cpu_din;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            rd_bank_q  <= 6'd0;
            cpu_dout_q <= 8'h00;
            vid_data_q <= 48'd0;
            vid_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            done_q     <= done_d;
            we_q       <= we_d;
            rd_bank_q  <= rd_bank_d;
            cpu_dout_q <= cpu_dout_d;
            vid_data_q <= vid_data_d;
            vid_ack_q  <= vid_ack_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors against a six-plane registered-read VRAM model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [5:0]  rd_bank, wr_bank;
    logic [7:0]  cpu_dout;
    logic        cpu_wait_n;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_ack;
    logic [47:0] vid_data;
    logic [12:0] ram_addr;
    logic [5:0]  ram_ce_n;
    logic        ram_we_n;
    logic [7:0]  ram_din;
    logic [47:0] ram_q;

    int n_chk  = 0;
    int n_pass = 0;

    // backdoor preload port into the memory model
    logic        bd_en = 1'b0;
    int          bd_p  = 0;
    logic [12:0] bd_a  = 13'd0;
    logic [7:0]  bd_d  = 8'h00;

    logic [7:0] mem [6][8192];

    always #5 clk = ~clk;

    vram_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .rd_bank(rd_bank), .wr_bank(wr_bank), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_din(ram_din),
        .ram_q(ram_q)
    );

    // VRAM model: per-plane write on enable+strobe, registered read of ram_addr
    always @(posedge clk) begin
        for (int p = 0; p < 6; p++) begin
            if (bd_en && bd_p == p)
                mem[p][bd_a] <= bd_d;
            else if (!ram_ce_n[p] && !ram_we_n)
                mem[p][ram_addr] <= ram_din;
            ram_q[8*p +: 8] <= mem[p][ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int p, input logic [12:0] a, input logic [7:0] d);
        bd_en = 1'b1; bd_p = p; bd_a = a; bd_d = d;
        tick();
        bd_en = 1'b0;
    endtask

    initial begin
        int grants, cpu_a_at, lat;
        logic [47:0] pat;

        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'd0; cpu_din = 8'h00;
        rd_bank = 6'd0; wr_bank = 6'd0; vid_req = 1'b0; vid_addr = 13'd0;
        tick(); tick();
        chk("rst_dout",   48'(cpu_dout), 48'h00);
        chk("rst_vdata",  vid_data, 48'h0);
        chk("rst_vack",   48'(vid_ack), 48'h0);
        chk("rst_ce",     48'(ram_ce_n), 48'h3f);
        chk("rst_we",     48'(ram_we_n), 48'h1);
        chk("rst_addr",   48'(ram_addr), 48'h0);
        chk("rst_wait",   48'(cpu_wait_n), 48'h1);
        reset_n = 1'b1;
        tick();

        pat = 48'h0123_4567_89AB;
        poke(1, 13'h0100, 8'h77);
        poke(0, 13'h0200, 8'h00);
        for (int p = 0; p < 6; p++) poke(p, 13'h1FFF, pat[8*p +: 8]);

        // write 0xA5 to planes 0 and 2 at 0x0100
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_din = 8'hA5;
        wr_bank = 6'b000101; rd_bank = 6'b111111;
        #1 chk("wr_stall_now", 48'(cpu_wait_n), 48'h0);
        tick();
        chk("wr_ce",   48'(ram_ce_n), 48'(6'b111010));
        chk("wr_we",   48'(ram_we_n), 48'h0);
        chk("wr_addr", 48'(ram_addr), 48'h0100);
        chk("wr_din",  48'(ram_din), 48'hA5);
        chk("wr_wait_a", 48'(cpu_wait_n), 48'h0);
        tick();
        chk("wr_wait_2cyc", 48'(cpu_wait_n), 48'h1);
        chk("wr_d_we",  48'(ram_we_n), 48'h1);
        chk("wr_d_ce",  48'(ram_ce_n), 48'h3f);
        cpu_req = 1'b0;
        tick();
        chk("wr_mem_p0", 48'(mem[0][13'h0100]), 48'hA5);
        chk("wr_mem_p1", 48'(mem[1][13'h0100]), 48'h77);
        chk("wr_mem_p2", 48'(mem[2][13'h0100]), 48'hA5);

        // read planes 0/1 -> 0x0F | 0xF0; plane 2 (0xA5) must be masked out
        poke(0, 13'h0100, 8'h0F);
        poke(1, 13'h0100, 8'hF0);
        cpu_req = 1'b1; cpu_we = 1'b0; rd_bank = 6'b000011; wr_bank = 6'b111111;
        tick();
        chk("rd_ce", 48'(ram_ce_n), 48'(6'b111100));
        chk("rd_we", 48'(ram_we_n), 48'h1);
        tick();
        chk("rd_wait", 48'(cpu_wait_n), 48'h1);
        tick();
        chk("rd_dout", 48'(cpu_dout), 48'hFF);
        chk("hold_wait", 48'(cpu_wait_n), 48'h1);
        chk("hold_ce", 48'(ram_ce_n), 48'h3f);
        tick();
        chk("hold_ce2", 48'(ram_ce_n), 48'h3f);
        cpu_req = 1'b0;
        tick();

        // read with rd_bank=0 -> 0x00, no plane enabled
        cpu_req = 1'b1; rd_bank = 6'd0;
        tick();
        chk("rd0_ce", 48'(ram_ce_n), 48'h3f);
        tick();
        chk("rd0_wait", 48'(cpu_wait_n), 48'h1);
        cpu_req = 1'b0;
        tick();
        chk("rd0_dout", 48'(cpu_dout), 48'h00);

        // write with wr_bank=0 completes without enabling a plane
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_din = 8'h99; wr_bank = 6'd0;
        tick();
        chk("wr0_ce", 48'(ram_ce_n), 48'h3f);
        tick();
        chk("wr0_wait", 48'(cpu_wait_n), 48'h1);
        cpu_req = 1'b0;
        tick();

        // video stream at 0x1FFF
        vid_req = 1'b1; vid_addr = 13'h1FFF;
        tick();
        chk("v_addr", 48'(ram_addr), 48'h1FFF);
        chk("v_ce",   48'(ram_ce_n), 48'h00);
        chk("v_we",   48'(ram_we_n), 48'h1);
        tick();
        chk("v_ack0", 48'(vid_ack), 48'h0);
        tick();
        chk("v_ack1", 48'(vid_ack), 48'h1);
        chk("v_data", vid_data, pat);
        chk("v_ce2",  48'(ram_ce_n), 48'h00);
        tick();
        chk("v_ack2", 48'(vid_ack), 48'h0);
        tick();
        chk("v_ack3", 48'(vid_ack), 48'h1);

        // starvation: CPU read issued during VID_A with video held
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100; rd_bank = 6'b000011;
        #1 chk("st_stall", 48'(cpu_wait_n), 48'h0);
        grants = 0; cpu_a_at = 0; lat = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ram_ce_n == 6'h00) grants++;
            if (ram_ce_n == 6'b111100) cpu_a_at = k;
            if (cpu_wait_n) begin
                lat = k;
                break;
            end
        end
        chk("st_grants", 48'(grants), 48'd4);
        chk("st_cpu_a",  48'(cpu_a_at), 48'd10);
        chk("st_lat",    48'(lat), 48'd11);
        vid_req = 1'b0; cpu_req = 1'b0;
        tick();
        chk("st_dout", 48'(cpu_dout), 48'hFF);
        tick(); tick();

        // reset during CPU_A of a write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_din = 8'h3C; wr_bank = 6'b000001;
        tick();
        chk("rw_we_a", 48'(ram_we_n), 48'h0);
        reset_n = 1'b0;
        #1 chk("rw_we_rst", 48'(ram_we_n), 48'h1);
        tick();
        chk("rw_we_idle", 48'(ram_we_n), 48'h1);
        chk("rw_ce_idle", 48'(ram_ce_n), 48'h3f);
        chk("rw_dout",    48'(cpu_dout), 48'h00);
        chk("rw_wait",    48'(cpu_wait_n), 48'h0);
        chk("rw_nowrite", 48'(mem[0][13'h0200]), 48'h00);
        reset_n = 1'b1;
        tick();
        chk("rw_again_we", 48'(ram_we_n), 48'h0);
        chk("rw_again_ce", 48'(ram_ce_n), 48'(6'b111110));
        tick();
        chk("rw_again_wait", 48'(cpu_wait_n), 48'h1);
        chk("rw_mem", 48'(mem[0][13'h0200]), 48'h3C);
        cpu_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
